// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// Queue entries are stored at the widest supported size (64-bit PC, 32-bit instruction).
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam int MAX_XLEN   = 64;
  localparam int MAX_INST_W = 32;

  typedef struct packed {
    logic [MAX_XLEN-1:0]   pc;
    logic [MAX_INST_W-1:0] inst;
    logic                  filled;
  } fq_entry_t;

  function automatic int fq_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int FQ_PTR_W = fq_ptr_w(4);

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at request time and filled by responses.
// Pointers carry one extra wrap bit so occupancy is a plain subtraction.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_alloc,
  input  logic [XLEN-1:0]          i_alloc_pc,
  input  logic                     i_fill,
  input  logic [INST_W-1:0]        i_fill_inst,
  input  logic                     i_pop,
  output logic                     o_head_valid,
  output logic [XLEN-1:0]          o_head_pc,
  output logic [INST_W-1:0]        o_head_inst,
  output logic [fq_ptr_w(DEPTH):0] o_count,
  output logic [fq_ptr_w(DEPTH):0] o_unfilled
);

  localparam int PW = fq_ptr_w(DEPTH);

  fq_entry_t       r_mem [DEPTH];
  logic [PW:0]     r_head;
  logic [PW:0]     r_fill;
  logic [PW:0]     r_tail;
  logic [PW-1:0]   w_head_idx;
  logic [PW-1:0]   w_fill_idx;
  logic [PW-1:0]   w_tail_idx;
  fq_entry_t       w_head;

  assign w_head_idx = r_head[PW-1:0];
  assign w_fill_idx = r_fill[PW-1:0];
  assign w_tail_idx = r_tail[PW-1:0];
  assign w_head     = r_mem[w_head_idx];

  assign o_count      = r_tail - r_head;
  assign o_unfilled   = r_tail - r_fill;
  assign o_head_valid = (o_count != '0) && w_head.filled;
  assign o_head_pc    = w_head.pc[XLEN-1:0];
  assign o_head_inst  = w_head.inst[INST_W-1:0];

  // Storage is cleared on reset so the decode-facing data reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_head <= '0;
      r_fill <= '0;
      r_tail <= '0;
    end else begin
      if (i_alloc) begin
        r_mem[w_tail_idx] <= '{pc: MAX_XLEN'(i_alloc_pc), inst: '0, filled: 1'b0};
        r_tail            <= r_tail + (PW+1)'(1);
      end
      if (i_fill) begin
        r_mem[w_fill_idx].inst   <= MAX_INST_W'(i_fill_inst);
        r_mem[w_fill_idx].filled <= 1'b1;
        r_fill                   <= r_fill + (PW+1)'(1);
      end
      if (i_pop) begin
        r_head <= r_head + (PW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, response
// collection and redirect handling with drop counting of stale in-flight responses.
//
// state   | meaning
// IDLE    | no request held; valid follows stall and credit
// PENDING | request presented but not accepted; valid and addr held
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_W   = 32,
  parameter int              FQ_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [XLEN-1:0]   dec_pc,
  output logic [INST_W-1:0] dec_inst
);

  localparam int CW = fq_ptr_w(FQ_DEPTH) + 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   w_drop_nxt;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_unfilled;
  logic [CW-1:0]   w_redir_drop;
  logic [CW:0]     w_used;
  logic            w_credit;
  logic            w_fire;
  logic            w_pop;
  logic            w_rsp_drop;
  logic            w_rsp_fill;

  // Credit uses registered counts only; a pop this cycle frees a slot next cycle.
  assign w_used   = {1'b0, w_count} + {1'b0, r_drop};
  assign w_credit = w_used < (CW+1)'(FQ_DEPTH);

  assign imem_req_valid = !rst && ((r_state == ST_PENDING) || (!stall && w_credit));
  assign imem_req_addr  = r_pc;

  assign w_fire     = imem_req_valid && imem_req_ready;
  assign w_pop      = dec_valid && dec_ready;
  assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_fill = imem_rsp_valid && (r_drop == '0) && (w_unfilled != '0);

  // Everything still owed by memory after a redirect becomes a drop.
  assign w_redir_drop = w_unfilled + r_drop + CW'(w_fire) - CW'(w_rsp_drop | w_rsp_fill);

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (imem_req_valid && !imem_req_ready) w_state_nxt = ST_PENDING;
        ST_PENDING: if (imem_req_ready) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_drop_nxt = r_drop;
    if (redirect_valid) begin
      w_drop_nxt = w_redir_drop;
    end else if (w_rsp_drop) begin
      w_drop_nxt = r_drop - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      if (redirect_valid) begin
        r_pc <= redirect_pc & ~XLEN'(3);
      end else if (w_fire) begin
        r_pc <= r_pc + XLEN'(INST_BYTES);
      end
    end
  end

  fetch_queue #(
    .XLEN   (XLEN),
    .INST_W (INST_W),
    .DEPTH  (FQ_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect_valid),
    .i_alloc      (w_fire),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_rsp_fill),
    .i_fill_inst  (imem_rsp_data),
    .i_pop        (w_pop),
    .o_head_valid (dec_valid),
    .o_head_pc    (dec_pc),
    .o_head_inst  (dec_inst),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory responder, queue-based reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              stall;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic [XLEN-1:0]   dec_pc;
  logic [INST_W-1:0] dec_inst;

  logic              rst2;
  logic              req_valid2;
  logic [XLEN-1:0]   req_addr2;
  logic              dec_valid2;
  logic [XLEN-1:0]   dec_pc2;
  logic [INST_W-1:0] dec_inst2;
  logic              one2;
  logic              zero2;
  logic [XLEN-1:0]   zpc2;
  logic [INST_W-1:0] zinst2;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(XLEN), .INST_W(INST_W), .FQ_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc), .dec_inst(dec_inst)
  );

  fetch_unit #(.XLEN(XLEN), .INST_W(INST_W), .FQ_DEPTH(DEPTH),
               .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_ready(one2), .imem_req_addr(req_addr2),
    .imem_rsp_valid(zero2), .imem_rsp_data(zinst2),
    .stall(zero2), .redirect_valid(zero2), .redirect_pc(zpc2),
    .dec_valid(dec_valid2), .dec_ready(one2), .dec_pc(dec_pc2), .dec_inst(dec_inst2)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: queue of fetched entries, drop count, next pc, held-request flag.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    bit          filled;
  } ment_t;

  ment_t       mq[$];
  int          m_drop = 0;
  logic [63:0] m_pc   = 64'h0;
  bit          m_pend = 1'b0;

  always @(negedge clk) begin : cmp
    bit    e_valid;
    bit    e_dv;
    bit    fire;
    bit    pop;
    bit    owned;
    int    unf;
    ment_t t;
    if (rst) begin
      chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
      chk("rst_dec_valid", 64'(dec_valid), 64'(0));
      chk("rst_dec_pc", dec_pc, 64'(0));
      chk("rst_dec_inst", 64'(dec_inst), 64'(0));
      mq.delete();
      m_drop = 0;
      m_pc   = 64'h0;
      m_pend = 1'b0;
    end else begin
      e_valid = m_pend || (!stall && (mq.size() + m_drop < DEPTH));
      e_dv    = (mq.size() > 0) && mq[0].filled;
      chk("req_valid", 64'(imem_req_valid), 64'(e_valid));
      if (e_valid) chk("req_addr", imem_req_addr, m_pc);
      chk("dec_valid", 64'(dec_valid), 64'(e_dv));
      if (e_dv) begin
        chk("dec_pc", dec_pc, mq[0].pc);
        chk("dec_inst", 64'(dec_inst), 64'(mq[0].inst));
      end
      fire = e_valid && imem_req_ready;
      pop  = e_dv && dec_ready;
      unf  = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      owned = imem_rsp_valid && (m_drop > 0 || unf > 0);
      if (imem_rsp_valid) chk("rsp_has_owner", 64'(owned), 64'(1));
      if (redirect_valid) begin
        m_drop = unf + m_drop + (fire ? 1 : 0) - (owned ? 1 : 0);
        mq.delete();
        m_pc   = {redirect_pc[63:2], 2'b00};
        m_pend = 1'b0;
      end else begin
        if (owned) begin
          if (m_drop > 0) begin
            m_drop--;
          end else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                t = mq[i];
                t.inst = imem_rsp_data;
                t.filled = 1'b1;
                mq[i] = t;
                break;
              end
            end
          end
        end
        if (pop) void'(mq.pop_front());
        if (fire) begin
          t.pc = m_pc;
          t.inst = 32'h0;
          t.filled = 1'b0;
          mq.push_back(t);
          m_pc = m_pc + 64'd4;
        end
        m_pend = e_valid && !imem_req_ready;
      end
    end
  end

  // In-order memory responder with configurable latency.
  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] fire_log[$];
  int          cyc = 0;
  int          mem_lat = 1;

  task automatic tick();
    logic        f;
    logic [63:0] a;
    mreq_t       r;
    @(negedge clk);
    f = imem_req_valid && imem_req_ready && !rst;
    a = imem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (imem_rsp_valid && memq.size() > 0) memq.delete(0);
    if (f) begin
      r.addr = a;
      r.due  = cyc + mem_lat - 1;
      memq.push_back(r);
      fire_log.push_back(a);
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    memq.delete();
    fire_log.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_dec(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      #1;
      if (dec_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int cnt;
    rst = 1'b1; rst2 = 1'b1;
    one2 = 1'b1; zero2 = 1'b0; zpc2 = '0; zinst2 = '0;
    stall = 1'b0; imem_req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1;
    chk("reset_req_valid", 64'(imem_req_valid), 64'(0));
    chk("reset_dec_valid", 64'(dec_valid), 64'(0));
    chk("reset_dec_pc", dec_pc, 64'h0);

    // zero-wait streaming
    mem_lat = 1;
    do_reset();
    #1;
    chk("t1_first_valid", 64'(imem_req_valid), 64'(1));
    chk("t1_first_addr", imem_req_addr, 64'h0);
    tick(); #1;
    chk("t1_second_addr", imem_req_addr, 64'h4);
    tick(); #1;
    chk("t1_dec_valid", 64'(dec_valid), 64'(1));
    chk("t1_dec_pc0", dec_pc, 64'h0);
    chk("t1_dec_inst0", 64'(dec_inst), 64'h5A5A_0F0F);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (dec_valid && dec_ready) cnt++;
    end
    chk("t1_no_bubbles", 64'(cnt), 64'(10));

    // decode back-pressure fills the queue
    dec_ready = 1'b0;
    do_reset();
    repeat (8) tick();
    #1;
    chk("t2_req_blocked", 64'(imem_req_valid), 64'(0));
    chk("t2_fires", 64'(fire_log.size()), 64'(4));
    chk("t2_head_pc", dec_pc, 64'h0);
    dec_ready = 1'b1;
    tick(); #1;
    chk("t2_resume_valid", 64'(imem_req_valid), 64'(1));
    chk("t2_resume_addr", imem_req_addr, 64'h10);
    repeat (6) tick();

    // request held across ready-low and stall
    do_reset();
    tick(); tick();
    imem_req_ready = 1'b0;
    #1;
    chk("t3_hold0_addr", imem_req_addr, 64'h8);
    tick(); stall = 1'b1; #1;
    chk("t3_hold1_valid", 64'(imem_req_valid), 64'(1));
    chk("t3_hold1_addr", imem_req_addr, 64'h8);
    tick(); stall = 1'b0; #1;
    chk("t3_hold2_addr", imem_req_addr, 64'h8);
    tick(); imem_req_ready = 1'b1; stall = 1'b1; #1;
    chk("t3_hold3_valid", 64'(imem_req_valid), 64'(1));
    tick(); #1;
    chk("t3_stalled", 64'(imem_req_valid), 64'(0));
    cnt = 0;
    foreach (fire_log[i]) if (fire_log[i] == 64'h8) cnt++;
    chk("t3_fire_once", 64'(cnt), 64'(1));
    stall = 1'b0;
    repeat (4) tick();

    // redirect with two requests in flight, 2-cycle memory
    mem_lat = 2;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h1003;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_new_valid", 64'(imem_req_valid), 64'(1));
    chk("t4_new_addr", imem_req_addr, 64'h1000);
    wait_dec(20, seen);
    chk("t4_dec_seen", 64'(seen), 64'(1));
    chk("t4_first_pc", dec_pc, 64'h1000);
    chk("t4_first_inst", 64'(dec_inst), 64'(inst_of(64'h1000)));
    repeat (4) tick();

    // redirect with simultaneous fire and response; back-to-back redirects
    mem_lat = 1;
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    repeat (3) tick();
    dec_ready = 1'b0;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h3000;
    tick();
    redirect_pc = 64'h4006;
    tick();
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    #1;
    chk("t5_b2b_addr", imem_req_addr, 64'h4004);
    wait_dec(20, seen);
    chk("t5_dec_seen", 64'(seen), 64'(1));
    chk("t5_first_pc", dec_pc, 64'h4004);
    repeat (3) tick();

    // asynchronous reset mid-stream
    #2;
    rst = 1'b1;
    memq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    #1;
    chk("t6_async_req_valid", 64'(imem_req_valid), 64'(0));
    chk("t6_async_dec_valid", 64'(dec_valid), 64'(0));
    chk("t6_async_dec_pc", dec_pc, 64'h0);
    chk("t6_async_dec_inst", 64'(dec_inst), 64'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("t6_restart_addr", imem_req_addr, 64'h0);
    repeat (3) tick();

    // PC wrap from the top of the address space
    #1;
    chk("t7_rst_valid", 64'(req_valid2), 64'(0));
    rst2 = 1'b0;
    #1;
    chk("t7_first_valid", 64'(req_valid2), 64'(1));
    chk("t7_first_addr", req_addr2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); #1;
    chk("t7_wrap_addr", req_addr2, 64'h0);
    tick(); #1;
    chk("t7_after_wrap", req_addr2, 64'h4);
    chk("t7_no_dec", 64'(dec_valid2), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor of the free-running PC fetch stage.
- Generates sequential instruction addresses from a reset vector and issues them over a valid/ready instruction-memory request channel.
- Collects in-order responses into a small fetch queue and hands {pc, inst} pairs to decode over a valid/ready channel.
- Supports stall and redirect (branch/jump/trap), flushing the queue and discarding stale in-flight responses.

Parameters:
- XLEN, 64, address/PC width.
- INST_W, 32, instruction width.
- FQ_DEPTH, 4, fetch-queue entries; also the maximum outstanding requests (power of 2, ≥2).
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address, always 4-byte aligned.
- imem_rsp_valid  in  1  response valid; responses return in order and cannot be back-pressured.
- imem_rsp_data  in  INST_W  instruction data.
- stall  in  1  blocks new request assertion.
- redirect_valid  in  1  redirect the fetch stream.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are forced to 0.
- dec_valid  out  1  head entry valid toward decode.
- dec_ready  in  1  decode accepts the head entry.
- dec_pc  out  XLEN  PC of the head entry.
- dec_inst  out  INST_W  instruction of the head entry.

Behaviour:
- Reset (async assert): pc=RESET_PC, queue empty, inflight=0, drop_cnt=0, imem_req_valid=0, dec_valid=0, dec_pc=0, dec_inst=0.
- First request appears in the first cycle after rst deasserts, with addr=RESET_PC.
- Issue: imem_req_valid=1 when (a request is pending) or (!stall and entries_alloc+drop_cnt < FQ_DEPTH).
  - A pending request holds valid and addr stable until imem_req_ready, even if stall rises.
  - Fire = valid & ready. On fire: allocate a queue entry at the tail with pc (filled=0), then pc <= pc+4 with XLEN wrap-around (all-ones-aligned wraps to 0).
- Response: imem_rsp_valid in a cycle.
  - If drop_cnt>0: discard and decrement drop_cnt.
  - Otherwise: write inst into the oldest unfilled entry (fill pointer) and set filled.
  - A response with no outstanding request is a protocol error; the bench asserts on it and the RTL ignores it.
- Decode output: dec_valid = head entry allocated & filled; dec_pc/dec_inst driven from the head entry. Pop on dec_valid & dec_ready.
- Latency:
  - Request fire at edge N, response at edge N+k, dec_valid visible from edge N+k.
  - Zero-wait memory (ready=1, response the next cycle) sustains one instruction per cycle with dec_ready=1.
- Redirect (highest priority, same edge):
  - pc <= redirect_pc & ~3.
  - All queue entries flushed, including ones allocated by a fire in the same cycle.
  - drop_cnt <= (unfilled allocated entries) + (drop_cnt) + (fire?1:0) − (rsp_valid?1:0).
  - Any pending unfired request is abandoned: valid may drop; the next cycle re-issues at the new pc.
  - A dec handshake in the redirect cycle completes, but nothing else from the old stream appears afterwards.
  - dec_valid is not combinationally dependent on redirect_valid.
  - Back-to-back redirects: the last one wins; drops accumulate correctly.
- Simultaneous events:
  - Fire and pop in the same cycle: both take effect, so a full queue can issue when popping only if the credit check already passed the previous cycle. The credit check uses registered counts and is not bypassed.
  - Response and pop of the same entry: not possible; the fill is visible the next cycle.
- Full condition: entries_alloc+drop_cnt == FQ_DEPTH blocks new issue; dec_ready low indefinitely produces no overflow and no lost responses.
- Counters are $clog2(FQ_DEPTH)+1 bits wide; pointers wrap modulo FQ_DEPTH.

Decomposition:
- Package fetch_pkg:
  - fq_entry_t {logic [XLEN-1:0] pc; logic [INST_W-1:0] inst; logic filled;}.
  - INST_BYTES=4.
  - FQ_PTR_W function/localparam.
- Sub-module fetch_queue: circular buffer with head, fill and tail pointers, flush input and occupancy output.
- fetch_unit top: PC register, request FSM (IDLE/PENDING), drop counter, credit logic.

Test Plan:
- Reset then zero-wait memory, dec_ready=1 → addresses 0,4,8,… one per cycle; dec_pc 0,4,8 with matching dec_inst; no bubbles after fill.
- dec_ready=0 with FQ_DEPTH=4 → exactly 4 requests fire, then imem_req_valid=0; release dec_ready → in-order drain, then issue resumes at 0x10.
- imem_req_ready low 3 cycles while stall pulses → imem_req_addr stable at 0x8 and valid held; fires once.
- 2-cycle memory latency, redirect to 0x1003 with 2 requests in flight → next request addr=0x1000; both old responses dropped; first dec_pc=0x1000.
- Redirect in the same cycle as a request fire and a response → drop_cnt correct; no stale instruction reaches decode.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → second address is 0 (wrap); rst asserted mid-stream → outputs return to reset values immediately (async).
